// File: rtl/imem_line_responder_if.sv
// imem_line_responder_if
//   Bundles the fetch-side request/response signals and the burst-memory
//   port of the instruction line responder.
//   slave  : the responder (drives imem_resp/imem_rdata and the burst request)
//   master : the fetch stage plus backing memory (drives requests, flush, beats)
//
//   imem_addr   [31:0] fetch word address, bits [1:0] ignored
//   imem_rmask  [3:0]  nonzero = read request
//   flush              fetch redirect, cancels any outstanding response
//   imem_resp          one-cycle response strobe
//   imem_rdata  [31:0] instruction word
//   bmem_addr   [31:0] line-aligned burst address
//   bmem_read          burst read request
//   bmem_ready         request accepted when bmem_read && bmem_ready
//   bmem_rdata  [BEAT_W-1:0] burst beat data
//   bmem_rvalid        beat valid, ascending address order
interface imem_line_responder_if #(
  parameter int BEAT_W = 64
);
  logic [31:0]       imem_addr;
  logic [3:0]        imem_rmask;
  logic              flush;
  logic              imem_resp;
  logic [31:0]       imem_rdata;
  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_ready;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  modport slave (
    input  imem_addr, imem_rmask, flush, bmem_ready, bmem_rdata, bmem_rvalid,
    output imem_resp, imem_rdata, bmem_addr, bmem_read
  );

  modport master (
    output imem_addr, imem_rmask, flush, bmem_ready, bmem_rdata, bmem_rvalid,
    input  imem_resp, imem_rdata, bmem_addr, bmem_read
  );
endinterface

// File: rtl/imem_line_responder.sv
// imem_line_responder
//   Responder end of the instruction-fetch interface. Keeps a single 32-byte
//   line buffer; hits answer one cycle after the request, misses fetch the
//   line as LINE_BEATS x BEAT_W-bit beats from the burst memory, install it,
//   then answer.
//
//   Ports:
//     clk  clock
//     rst  synchronous, active-high reset
//     bus  imem_line_responder_if.slave (fetch request/response + burst port)
//
//   Optional feature, macro IMEM_PERF_CNT_EN: adds saturating 32-bit
//   hit_count / miss_count registers (hierarchically readable, no ports).
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | accept requests; hits respond next cycle
//   MISS_REQ | hold bmem_read/bmem_addr until bmem_ready
//   FILL     | write incoming beats into the line buffer
//   RESP     | present the latched word (unless cancelled by flush)
module imem_line_responder #(
  parameter int LINE_BEATS = 4,
  parameter int BEAT_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_line_responder_if.slave  bus
);

  localparam int CNT_W = $clog2(LINE_BEATS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MISS_REQ = 2'd1,
    FILL     = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [BEAT_W-1:0] line_data [LINE_BEATS];
  logic              line_valid, line_valid_nxt;
  logic [26:0]       line_tag, line_tag_nxt;
  logic [26:0]       miss_tag, miss_tag_nxt;
  logic [2:0]        miss_sel, miss_sel_nxt;   // {beat, word-in-beat}
  logic              cancel, cancel_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;

  logic              resp_q, resp_nxt;
  logic [31:0]       rdata_q, rdata_nxt;
  logic              bread_q, bread_nxt;
  logic [31:0]       baddr_q, baddr_nxt;

  logic              req;
  logic [26:0]       req_tag;
  logic              hit;
  logic              fill_we;
  logic              hit_acc;
  logic              miss_acc;
  logic [BEAT_W-1:0] hit_beat;
  logic [31:0]       hit_word;
  logic [BEAT_W-1:0] miss_beat;
  logic [31:0]       miss_word;

  logic              unused_addr_lsb;
  assign unused_addr_lsb = ^bus.imem_addr[1:0];

  assign req      = (bus.imem_rmask != 4'd0) && !bus.flush;
  assign req_tag  = bus.imem_addr[31:5];
  assign hit      = line_valid && (req_tag == line_tag);
  assign fill_we  = (state == FILL) && bus.bmem_rvalid;

  assign hit_beat  = line_data[bus.imem_addr[4:3]];
  assign hit_word  = bus.imem_addr[2] ? hit_beat[63:32] : hit_beat[31:0];
  assign miss_beat = line_data[miss_sel[2:1]];
  assign miss_word = miss_sel[0] ? miss_beat[63:32] : miss_beat[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      line_valid <= 1'b0;
      line_tag   <= '0;
      miss_tag   <= '0;
      miss_sel   <= '0;
      cancel     <= 1'b0;
      beat_cnt   <= '0;
      resp_q     <= 1'b0;
      rdata_q    <= '0;
      bread_q    <= 1'b0;
      baddr_q    <= '0;
    end else begin
      state      <= state_nxt;
      line_valid <= line_valid_nxt;
      line_tag   <= line_tag_nxt;
      miss_tag   <= miss_tag_nxt;
      miss_sel   <= miss_sel_nxt;
      cancel     <= cancel_nxt;
      beat_cnt   <= beat_cnt_nxt;
      resp_q     <= resp_nxt;
      rdata_q    <= rdata_nxt;
      bread_q    <= bread_nxt;
      baddr_q    <= baddr_nxt;
    end
  end

  // Line storage needs no reset; line_valid guards it.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      line_data[beat_cnt] <= bus.bmem_rdata;
    end
  end

  always_comb begin
    state_nxt      = state;
    line_valid_nxt = line_valid;
    line_tag_nxt   = line_tag;
    miss_tag_nxt   = miss_tag;
    miss_sel_nxt   = miss_sel;
    cancel_nxt     = cancel;
    beat_cnt_nxt   = beat_cnt;
    resp_nxt       = 1'b0;
    rdata_nxt      = rdata_q;
    bread_nxt      = bread_q;
    baddr_nxt      = baddr_q;
    hit_acc        = 1'b0;
    miss_acc       = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            resp_nxt  = 1'b1;
            rdata_nxt = hit_word;
            hit_acc   = 1'b1;
          end else begin
            miss_tag_nxt = req_tag;
            miss_sel_nxt = bus.imem_addr[4:2];
            bread_nxt    = 1'b1;
            baddr_nxt    = {req_tag, 5'b0};
            miss_acc     = 1'b1;
            state_nxt    = MISS_REQ;
          end
        end
      end

      MISS_REQ: begin
        if (bus.flush) cancel_nxt = 1'b1;
        if (bus.bmem_ready) begin
          bread_nxt      = 1'b0;
          beat_cnt_nxt   = '0;
          // The old line is gone as soon as the first beat may land.
          line_valid_nxt = 1'b0;
          state_nxt      = FILL;
        end
      end

      FILL: begin
        if (bus.flush) cancel_nxt = 1'b1;
        if (bus.bmem_rvalid) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (beat_cnt == CNT_W'(LINE_BEATS - 1)) begin
            line_valid_nxt = 1'b1;
            line_tag_nxt   = miss_tag;
            // A cancelled miss still installs the line but skips RESP.
            state_nxt      = (cancel || bus.flush) ? IDLE : RESP;
          end
        end
      end

      RESP: begin
        if (!cancel && !bus.flush) begin
          resp_nxt  = 1'b1;
          rdata_nxt = miss_word;
        end
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    if (state_nxt == IDLE) cancel_nxt = 1'b0;
  end

  assign bus.imem_resp  = resp_q;
  assign bus.imem_rdata = rdata_q;
  assign bus.bmem_read  = bread_q;
  assign bus.bmem_addr  = baddr_q;

`ifdef IMEM_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_acc && (hit_count != 32'hFFFF_FFFF)) hit_count <= hit_count + 32'd1;
      if (miss_acc && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = hit_acc ^ miss_acc;
`endif

endmodule

// File: tb/tb_imem_line_responder.sv
// tb_imem_line_responder
//   Directed scenarios for imem_line_responder. Expected responses (data and
//   cycle of arrival) go into a scoreboard queue when a request is issued; a
//   monitor pops and compares whenever imem_resp is seen. A small burst
//   memory model answers bmem_read with configurable ready delay and beat gap.
module tb_imem_line_responder;

  logic clk;
  logic rst;
  int   cyc;

  imem_line_responder_if #(.BEAT_W(64)) bus ();

  imem_line_responder #(.LINE_BEATS(4), .BEAT_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;
  int   resp_count;
  int   n_accepts;
  int   ready_delay;
  int   beat_gap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Words hold their own byte address, except line 0x1000 which uses the
  // 0x00000000, 0x11111111, ... 0x77777777 pattern.
  function automatic logic [63:0] beat_of(input logic [31:0] line, input int i);
    logic [31:0] lo, hi;
    if (line == 32'h0000_1000) begin
      lo = 32'(2 * i) * 32'h1111_1111;
      hi = 32'(2 * i + 1) * 32'h1111_1111;
    end else begin
      lo = line + 32'(8 * i);
      hi = line + 32'(8 * i + 4);
    end
    return {hi, lo};
  endfunction

  // Burst memory model
  initial begin
    bit          acc;
    bit          m_busy;
    int          waitc;
    int          nbeat;
    int          gapc;
    logic [31:0] acc_line;
    acc = 0; m_busy = 0; waitc = 0; nbeat = 0; gapc = 0; acc_line = '0;
    bus.bmem_ready  = 1'b0;
    bus.bmem_rvalid = 1'b0;
    bus.bmem_rdata  = '0;
    forever begin
      @(negedge clk);
      acc = (bus.bmem_read === 1'b1) && (bus.bmem_ready === 1'b1) && !rst;
      if (acc) acc_line = bus.bmem_addr;
      @(posedge clk);
      #2;
      bus.bmem_rvalid = 1'b0;
      bus.bmem_ready  = 1'b0;
      if (rst) begin
        m_busy = 0;
        waitc  = 0;
      end else begin
        if (acc) begin
          n_accepts++;
          m_busy = 1;
          nbeat  = 0;
          gapc   = 0;
          waitc  = 0;
        end
        if (m_busy) begin
          if (gapc == 0) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = beat_of(acc_line, nbeat);
            nbeat++;
            gapc = beat_gap;
            if (nbeat == 4) m_busy = 0;
          end else begin
            gapc--;
          end
        end else if (bus.bmem_read === 1'b1) begin
          bus.bmem_ready = (waitc >= ready_delay);
          waitc++;
        end
      end
    end
  end

  // Response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.imem_resp === 1'b1) begin
        resp_count++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got data 0x%08h with no response pending (cycle %0d)",
                   bus.imem_rdata, cyc);
        end else begin
          e = sb.pop_front();
          chk("resp_data", bus.imem_rdata, e.data);
          chk("resp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic req(input logic [31:0] a, input logic [3:0] m, input bit expect_resp,
                     input logic [31:0] d, input int lat);
    exp_t e;
    bus.imem_addr  = a;
    bus.imem_rmask = m;
    if (expect_resp) begin
      e.data = d;
      e.cyc  = cyc + lat;
      sb.push_back(e);
    end
    step();
    bus.imem_rmask = 4'd0;
  endtask

  task automatic drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: %0d responses outstanding, required 0", name, sb.size());
      sb.delete();
    end
    repeat (3) step();
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_resp"},  32'(bus.imem_resp), 32'h0);
    chk({name, "_rdata"}, bus.imem_rdata, 32'h0);
    chk({name, "_bread"}, 32'(bus.bmem_read), 32'h0);
    chk({name, "_baddr"}, bus.bmem_addr, 32'h0);
  endtask

  initial begin
    int acc0;
    int rc0;
    total = 0; bad = 0; resp_count = 0; n_accepts = 0;
    ready_delay = 0; beat_gap = 0;
    rst = 1'b1;
    bus.imem_addr  = '0;
    bus.imem_rmask = 4'd0;
    bus.flush      = 1'b0;
    step();
    step();
    chk_outputs_zero("reset");
    rst = 1'b0;
    step();

    // Cold miss on 0x1008: one accepted burst of line 0x1000, resp at +7.
    acc0 = n_accepts;
    req(32'h0000_1008, 4'hF, 1, 32'h2222_2222, 7);
    chk("cold_bread", 32'(bus.bmem_read), 32'h1);
    chk("cold_baddr", bus.bmem_addr, 32'h0000_1000);
    step();
    chk("cold_bread_drop", 32'(bus.bmem_read), 32'h0);
    drain("cold", 30);
    chk("cold_accepts", 32'(n_accepts - acc0), 32'd1);

    // Hit streak: three consecutive requests, three consecutive responses.
    rc0 = resp_count;
    req(32'h0000_1000, 4'hF, 1, 32'h0000_0000, 1);
    req(32'h0000_1004, 4'h1, 1, 32'h1111_1111, 1);
    req(32'h0000_101C, 4'h8, 1, 32'h7777_7777, 1);
    drain("hits", 10);
    chk("hits_count", 32'(resp_count - rc0), 32'd3);

    // Backpressure: ready low 5 cycles, beats with 2-cycle gaps.
    ready_delay = 5;
    beat_gap    = 2;
    acc0 = n_accepts;
    rc0  = resp_count;
    req(32'h0000_2000, 4'hF, 1, 32'h0000_2000, 18);
    for (int i = 0; i < 6; i++) begin
      chk("bp_bread_hold", 32'(bus.bmem_read), 32'h1);
      chk("bp_baddr_hold", bus.bmem_addr, 32'h0000_2000);
      step();
    end
    chk("bp_bread_drop", 32'(bus.bmem_read), 32'h0);
    drain("bp", 40);
    chk("bp_accepts", 32'(n_accepts - acc0), 32'd1);
    chk("bp_resps", 32'(resp_count - rc0), 32'd1);
    ready_delay = 0;
    beat_gap    = 0;

    // Flush during the second beat of the 0x3000 fill: no response, line kept.
    acc0 = n_accepts;
    rc0  = resp_count;
    req(32'h0000_3000, 4'hF, 0, 32'h0, 0);
    step();
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    repeat (8) step();
    chk("flush_fill_resps", 32'(resp_count - rc0), 32'd0);
    req(32'h0000_3004, 4'hF, 1, 32'h0000_3004, 1);
    drain("flush_fill_hit", 10);
    chk("flush_fill_accepts", 32'(n_accepts - acc0), 32'd1);

    // Flush together with a hit request: request ignored.
    rc0 = resp_count;
    bus.flush = 1'b1;
    req(32'h0000_3008, 4'hF, 0, 32'h0, 0);
    bus.flush = 1'b0;
    repeat (3) step();
    chk("flush_hit_resps", 32'(resp_count - rc0), 32'd0);
    req(32'h0000_3008, 4'h1, 1, 32'h0000_3008, 1);
    drain("post_flush_hit", 10);

    // Request during FILL is ignored: one burst, one response.
    acc0 = n_accepts;
    rc0  = resp_count;
    req(32'h0000_4000, 4'hF, 1, 32'h0000_4000, 7);
    step();
    req(32'h0000_4010, 4'hF, 0, 32'h0, 0);
    drain("fill_req", 30);
    chk("fill_req_accepts", 32'(n_accepts - acc0), 32'd1);
    chk("fill_req_resps", 32'(resp_count - rc0), 32'd1);

    // Reset mid-fill, then refetch the same line.
    rc0 = resp_count;
    req(32'h0000_5000, 4'hF, 0, 32'h0, 0);
    step();
    step();
    rst = 1'b1;
    step();
    chk_outputs_zero("rst_fill");
    rst = 1'b0;
    repeat (3) step();
    chk("rst_fill_resps", 32'(resp_count - rc0), 32'd0);
    acc0 = n_accepts;
    req(32'h0000_5000, 4'hF, 1, 32'h0000_5000, 7);
    drain("refetch", 30);
    chk("refetch_accepts", 32'(n_accepts - acc0), 32'd1);

    // Reset with a valid line installed: the line must be forgotten.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    acc0 = n_accepts;
    req(32'h0000_5004, 4'hF, 1, 32'h0000_5004, 7);
    drain("rst_valid", 30);
    chk("rst_valid_accepts", 32'(n_accepts - acc0), 32'd1);

    // Top-of-memory line.
    req(32'hFFFF_FFFC, 4'hF, 1, 32'hFFFF_FFFC, 7);
    chk("wrap_baddr", bus.bmem_addr, 32'hFFFF_FFE0);
    drain("wrap", 30);
    req(32'hFFFF_FFE0, 4'h2, 1, 32'hFFFF_FFE0, 1);
    drain("wrap_hit", 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imem_line_responder.md
Name: imem_line_responder

Overview:
- Responder end of the instruction-fetch memory interface (imem_addr/imem_rmask -> imem_resp/imem_rdata) that the fetch stage initiates on.
- Holds one 32-byte line buffer and serves word reads out of it.
- On a miss, it fetches the line from the backing burst memory as 4 x 64-bit beats, installs it, then responds.
- Sits between the fetch stage and the burst memory port.

Parameters:
- LINE_BEATS, 4, number of 64-bit beats per line (line = 32 bytes; fixed relationship, not tested at other values).
- BEAT_W, 64, backing-memory beat width in bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- imem_addr  in  32  fetch word address; bits [1:0] ignored
- imem_rmask  in  4  nonzero = read request this cycle
- flush  in  1  fetch redirect (branch mispredict); cancels any outstanding response
- imem_resp  out  1  one-cycle response strobe
- imem_rdata  out  32  instruction word, valid when imem_resp=1
- bmem_addr  out  32  line-aligned burst address
- bmem_read  out  1  burst read request
- bmem_ready  in  1  memory accepts request when bmem_read && bmem_ready
- bmem_rdata  in  64  burst beat data
- bmem_rvalid  in  1  beat valid; beats arrive in ascending address order

Behaviour:
- Reset values:
  - imem_resp=0, imem_rdata=0, bmem_read=0, bmem_addr=0.
  - line_valid=0, state=IDLE, beat counter=0.
- Address split: tag=addr[31:5], beat=addr[4:3], word-in-beat=addr[2] (0 = low half [31:0]).
- Request rule: in IDLE, every cycle with imem_rmask!=0 and flush=0 is one distinct request. The requester must not re-present an accepted request. Requests in any non-IDLE state are ignored and not queued.
- States: IDLE, MISS_REQ, FILL, RESP.
- IDLE, hit (line_valid && tag match):
  - Register the selected word; imem_resp=1 next cycle.
  - Stay in IDLE, so back-to-back hits give 1 response per cycle at latency 1.
- IDLE, miss:
  - Latch tag and word select; go to MISS_REQ.
  - From the next cycle, drive bmem_read=1 and bmem_addr={addr[31:5],5'b0}.
- MISS_REQ:
  - Hold bmem_read and bmem_addr until the cycle where bmem_ready=1.
  - In that cycle, deassert bmem_read next cycle, clear the beat counter, go to FILL.
- FILL:
  - Each bmem_rvalid=1 writes bmem_rdata into line beat [counter] and increments the counter.
  - On the 4th beat, set line_valid=1 and tag=latched tag, then go to RESP.
  - line_valid is 0 during FILL (the old line is unusable once overwrite starts).
- RESP:
  - Drive imem_resp=1 for one cycle with the latched word, then go to IDLE.
  - Miss latency, request to resp with ready=1 immediately and beats back-to-back: 1 (to MISS_REQ) + 1 (accept) + 4 beats + 1 (RESP) = 7 cycles.
- Flush:
  - Any state: the outstanding response is cancelled.
  - Flush asserted with a hit request: no resp next cycle.
  - Flush in MISS_REQ or FILL: the burst still completes and the line is installed, but RESP is skipped and the block returns to IDLE after the 4th beat.
  - The cancel is a sticky flag cleared on entering IDLE.
  - A request in the same cycle as flush is ignored.
  - Flush in the same cycle imem_resp=1: resp is still visible; the requester discards it.
- Boundaries:
  - bmem_rvalid in IDLE, MISS_REQ or RESP is ignored.
  - Reset mid-fill: immediate return to IDLE with line_valid=0. The memory model is reset alongside, so no stale beats are expected.
  - imem_rmask value beyond nonzero is ignored; a full word is always returned.
  - Address wrap 0xFFFFFFE0 line is handled normally; no carry.

Optional Feature:
- IMEM_PERF_CNT_EN defined: two 32-bit internal counters, hit_count and miss_count.
  - Each increments on an accepted hit or an accepted miss request.
  - Flushed requests still count.
  - Both reset to 0 and saturate at 0xFFFFFFFF.
  - Readable hierarchically by the bench; no ports added.
- Undefined: counters absent; behaviour otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: after reset, request addr 0x00001008; bmem_ready=1; beats 0x11111111_00000000, 0x33333333_22222222, 0x55555555_44444444, 0x77777777_66666666 back-to-back.
  - Required: bmem_addr=0x00001000, one accepted bmem_read; imem_resp at cycle 7 with imem_rdata=0x22222222.
- Hit streak: after the line is filled, requests 0x1000, 0x1004, 0x101C on consecutive cycles -> resps on 3 consecutive cycles with data 0x00000000, 0x11111111, 0x77777777.
- Backpressure:
  - Stimulus: miss on 0x2000 with bmem_ready low for 5 cycles, then beats with 2-cycle gaps.
  - Required: bmem_read and bmem_addr held stable for 6 cycles; exactly one resp, after the 4th beat.
- Flush mid-fill:
  - Stimulus: flush during beat 2 of a fill of 0x3000.
  - Required: no imem_resp for that request; a following request to 0x3004 hits with 1-cycle latency.
- Flush on hit / ignored request:
  - Flush with a hit request -> no resp next cycle.
  - A request issued during FILL -> no extra response and no second bmem_read.
- Reset mid-fill: rst during FILL -> all outputs 0 next cycle; a subsequent request to the same line misses and refetches (bmem_read asserted again).
